// File: rtl/fwd_hazard_ctrl.sv
// EX-stage operand forwarding selector and load-use stall generator.
// Shadows rd/valid/load info of in-flight instructions across EX, MEM and WB.
module fwd_hazard_ctrl #(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [ADDR_W-1:0] id_rs1,
  input  logic [ADDR_W-1:0] id_rs2,
  input  logic [ADDR_W-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              flush,
  output logic              stall,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic [ADDR_W-1:0] ex_rd,
  output logic [ADDR_W-1:0] mem_rd,
  output logic [ADDR_W-1:0] wb_rd,
  output logic              wb_reg_write
);

  localparam logic [ADDR_W-1:0] X0 = {ADDR_W{1'b0}};

  logic              ex_valid_q, ex_valid_d;
  logic [ADDR_W-1:0] ex_rs1_q, ex_rs1_d;
  logic [ADDR_W-1:0] ex_rs2_q, ex_rs2_d;
  logic [ADDR_W-1:0] ex_rd_q, ex_rd_d;
  logic              ex_reg_write_q, ex_reg_write_d;
  logic              ex_mem_read_q, ex_mem_read_d;

  logic              mem_valid_q;
  logic [ADDR_W-1:0] mem_rd_q;
  logic              mem_reg_write_q;
  logic              mem_mem_read_q;

  logic              wb_valid_q;
  logic [ADDR_W-1:0] wb_rd_q;
  logic              wb_reg_write_q;

  logic              stall_s;

  // MEM (younger) result takes precedence over WB; x0 is never forwarded.
  function automatic logic [1:0] pick_src(
    input logic              ex_v,
    input logic [ADDR_W-1:0] rs,
    input logic              m_v,
    input logic              m_w,
    input logic [ADDR_W-1:0] m_rd,
    input logic              w_v,
    input logic              w_w,
    input logic [ADDR_W-1:0] w_rd
  );
    logic [1:0] sel;
    sel = 2'd0;
    if (ex_v && m_v && m_w && (m_rd != X0) && (m_rd == rs)) begin
      sel = 2'd2;
    end else if (ex_v && w_v && w_w && (w_rd != X0) && (w_rd == rs)) begin
      sel = 2'd1;
    end else begin
      sel = 2'd0;
    end
    return sel;
  endfunction

  // Load-use detection against the instruction currently in ID.
  always_comb begin
    stall_s = 1'b0;
    if (!flush && id_valid && ex_valid_q && ex_mem_read_q && (ex_rd_q != X0) &&
        ((ex_rd_q == id_rs1) || (ex_rd_q == id_rs2))) begin
      stall_s = 1'b1;
    end else begin
      stall_s = 1'b0;
    end
  end

  // EX stage load: flush and stall both insert a bubble.
  always_comb begin
    ex_valid_d      = 1'b0;
    ex_rs1_d        = X0;
    ex_rs2_d        = X0;
    ex_rd_d         = X0;
    ex_reg_write_d  = 1'b0;
    ex_mem_read_d   = 1'b0;
    if (flush || stall_s) begin
      ex_valid_d = 1'b0;
    end else begin
      ex_valid_d     = id_valid;
      ex_rs1_d       = id_rs1;
      ex_rs2_d       = id_rs2;
      ex_rd_d        = id_rd;
      ex_reg_write_d = id_reg_write & id_valid;
      ex_mem_read_d  = id_mem_read & id_valid;
    end
  end

  // Shadow pipeline registers; MEM and WB advance every edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_q      <= 1'b0;
      ex_rs1_q        <= X0;
      ex_rs2_q        <= X0;
      ex_rd_q         <= X0;
      ex_reg_write_q  <= 1'b0;
      ex_mem_read_q   <= 1'b0;
      mem_valid_q     <= 1'b0;
      mem_rd_q        <= X0;
      mem_reg_write_q <= 1'b0;
      mem_mem_read_q  <= 1'b0;
      wb_valid_q      <= 1'b0;
      wb_rd_q         <= X0;
      wb_reg_write_q  <= 1'b0;
    end else begin
      ex_valid_q      <= ex_valid_d;
      ex_rs1_q        <= ex_rs1_d;
      ex_rs2_q        <= ex_rs2_d;
      ex_rd_q         <= ex_rd_d;
      ex_reg_write_q  <= ex_reg_write_d;
      ex_mem_read_q   <= ex_mem_read_d;
      mem_valid_q     <= ex_valid_q;
      mem_rd_q        <= ex_rd_q;
      mem_reg_write_q <= ex_reg_write_q;
      mem_mem_read_q  <= ex_mem_read_q;
      wb_valid_q      <= mem_valid_q;
      wb_rd_q         <= mem_rd_q;
      wb_reg_write_q  <= mem_reg_write_q;
    end
  end

  assign stall        = stall_s;
  assign fwd_a_sel    = pick_src(ex_valid_q, ex_rs1_q, mem_valid_q, mem_reg_write_q, mem_rd_q,
                                 wb_valid_q, wb_reg_write_q, wb_rd_q);
  assign fwd_b_sel    = pick_src(ex_valid_q, ex_rs2_q, mem_valid_q, mem_reg_write_q, mem_rd_q,
                                 wb_valid_q, wb_reg_write_q, wb_rd_q);
  assign ex_rd        = ex_rd_q;
  assign mem_rd       = mem_rd_q;
  assign wb_rd        = wb_rd_q;
  assign wb_reg_write = wb_valid_q & wb_reg_write_q;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Scoreboard bench for fwd_hazard_ctrl: directed hazard scenarios plus a random stream
// checked against an independent pipeline model.
module tb_fwd_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_reg_write, id_mem_read, flush;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       stall, wb_reg_write;
  logic [1:0] fwd_a_sel, fwd_b_sel;
  logic [4:0] ex_rd, mem_rd, wb_rd;

  fwd_hazard_ctrl #(.ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .flush(flush),
    .stall(stall), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .ex_rd(ex_rd),
    .mem_rd(mem_rd), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       st;
    logic [1:0] fa;
    logic [1:0] fb;
    logic [4:0] exr;
    logic [4:0] memr;
    logic [4:0] wbr;
    logic       wbw;
    logic       mem_ld;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // reference model state
  logic       e_v, e_w, e_l, m_v, m_w, m_l, w_v, w_w;
  logic [4:0] e_rs1, e_rs2, e_rd, m_rd, w_rd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    {e_v, e_w, e_l, m_v, m_w, m_l, w_v, w_w} = '0;
    {e_rs1, e_rs2, e_rd, m_rd, w_rd} = '0;
  endtask

  function automatic logic [1:0] ref_sel(input logic [4:0] rs);
    if (!e_v) return 2'd0;
    if (m_v && m_w && m_rd != 5'd0 && m_rd == rs) return 2'd2;
    if (w_v && w_w && w_rd != 5'd0 && w_rd == rs) return 2'd1;
    return 2'd0;
  endfunction

  // one cycle: drive ID, sample outputs at negedge, advance model at posedge
  task automatic step(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [4:0] rd, input logic rw, input logic mr, input logic fl,
                      output logic st_o, output logic [1:0] fa_o, output logic [1:0] fb_o,
                      output logic wbw_o);
    exp_t e;
    id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_reg_write = rw; id_mem_read = mr; flush = fl;
    e.st     = !fl && v && e_v && e_l && e_rd != 5'd0 && (e_rd == rs1 || e_rd == rs2);
    e.fa     = ref_sel(e_rs1);
    e.fb     = ref_sel(e_rs2);
    e.exr    = e_rd;
    e.memr   = m_rd;
    e.wbr    = w_rd;
    e.wbw    = w_v && w_w;
    e.mem_ld = m_l;
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    chk("stall", stall, e.st);
    chk("fwd_a", fwd_a_sel, e.fa);
    chk("fwd_b", fwd_b_sel, e.fb);
    chk("ex_rd", ex_rd, e.exr);
    chk("mem_rd", mem_rd, e.memr);
    chk("wb_rd", wb_rd, e.wbr);
    chk("wb_rw", wb_reg_write, e.wbw);
    chk("a_not3", fwd_a_sel == 2'd3, 1'b0);
    chk("b_not3", fwd_b_sel == 2'd3, 1'b0);
    chk("a_noload", (fwd_a_sel == 2'd2) && e.mem_ld, 1'b0);
    chk("b_noload", (fwd_b_sel == 2'd2) && e.mem_ld, 1'b0);
    st_o = stall; fa_o = fwd_a_sel; fb_o = fwd_b_sel; wbw_o = wb_reg_write;
    @(posedge clk);
    w_v = m_v; w_rd = m_rd; w_w = m_w;
    m_v = e_v; m_rd = e_rd; m_w = e_w; m_l = e_l;
    if (fl || e.st) begin
      {e_v, e_w, e_l} = '0; {e_rs1, e_rs2, e_rd} = '0;
    end else begin
      e_v = v; e_rs1 = rs1; e_rs2 = rs2; e_rd = rd; e_w = rw & v; e_l = mr & v;
    end
    #1;
  endtask

  task automatic nop(output logic st_o, output logic [1:0] fa_o, output logic [1:0] fb_o,
                     output logic wbw_o);
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, st_o, fa_o, fb_o, wbw_o);
  endtask

  logic       st, w;
  logic [1:0] fa, fb;
  logic       r_v, r_w, r_l, r_f;
  logic [4:0] r_rs1, r_rs2, r_rd;

  initial begin
    rst = 1'b1;
    {id_valid, id_reg_write, id_mem_read, flush} = '0;
    {id_rs1, id_rs2, id_rd} = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", stall, 1'b0);
    chk("rst_fa", fwd_a_sel, 2'd0);
    chk("rst_wbw", wb_reg_write, 1'b0);
    rst = 1'b0;

    // T1: fill stages, then async reset mid-clock
    step(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0, st, fa, fb, w);
    step(1'b1, 5'd3, 5'd3, 5'd4, 1'b1, 1'b0, 1'b0, st, fa, fb, w);
    step(1'b1, 5'd4, 5'd3, 5'd8, 1'b1, 1'b1, 1'b0, st, fa, fb, w);
    id_valid = 1'b1; id_rs1 = 5'd8; id_rs2 = 5'd0; id_mem_read = 1'b0; flush = 1'b0;
    #2;
    chk("t1_pre_stall", stall, 1'b1);
    rst = 1'b1;
    #1;
    chk("t1_stall", stall, 1'b0);
    chk("t1_fa", fwd_a_sel, 2'd0);
    chk("t1_fb", fwd_b_sel, 2'd0);
    chk("t1_exrd", ex_rd, 5'd0);
    chk("t1_memrd", mem_rd, 5'd0);
    chk("t1_wbrd", wb_rd, 5'd0);
    chk("t1_wbw", wb_reg_write, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    repeat (3) begin
      nop(st, fa, fb, w);
      chk("t1_idle_a", fa, 2'd0);
      chk("t1_idle_st", st, 1'b0);
    end

    // T2: EX/MEM forward
    step(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0, st, fa, fb, w);
    step(1'b1, 5'd5, 5'd6, 5'd10, 1'b1, 1'b0, 1'b0, st, fa, fb, w);
    nop(st, fa, fb, w);
    chk("t2_fa", fa, 2'd2);
    chk("t2_fb", fb, 2'd0);
    step(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0, st, fa, fb, w);
    step(1'b1, 5'd6, 5'd5, 5'd10, 1'b1, 1'b0, 1'b0, st, fa, fb, w);
    nop(st, fa, fb, w);
    chk("t2_fb2", fb, 2'd2);

    // T3: MEM/WB forward, then MEM priority
    step(1'b1, 5'd1, 5'd2, 5'd7, 1'b1, 1'b0, 1'b0, st, fa, fb, w);
    step(1'b1, 5'd1, 5'd2, 5'd11, 1'b1, 1'b0, 1'b0, st, fa, fb, w);
    step(1'b1, 5'd7, 5'd2, 5'd12, 1'b1, 1'b0, 1'b0, st, fa, fb, w);
    nop(st, fa, fb, w);
    chk("t3_wb", fa, 2'd1);
    step(1'b1, 5'd1, 5'd2, 5'd7, 1'b1, 1'b0, 1'b0, st, fa, fb, w);
    step(1'b1, 5'd1, 5'd2, 5'd7, 1'b1, 1'b0, 1'b0, st, fa, fb, w);
    step(1'b1, 5'd7, 5'd2, 5'd12, 1'b1, 1'b0, 1'b0, st, fa, fb, w);
    nop(st, fa, fb, w);
    chk("t3_prio", fa, 2'd2);

    // T4: load-use stall, then x0 load
    step(1'b1, 5'd1, 5'd2, 5'd9, 1'b1, 1'b1, 1'b0, st, fa, fb, w);
    step(1'b1, 5'd1, 5'd9, 5'd13, 1'b1, 1'b0, 1'b0, st, fa, fb, w);
    chk("t4_stall", st, 1'b1);
    step(1'b1, 5'd1, 5'd9, 5'd13, 1'b1, 1'b0, 1'b0, st, fa, fb, w);
    chk("t4_one_cycle", st, 1'b0);
    chk("t4_bubble_fb", fb, 2'd0);
    nop(st, fa, fb, w);
    chk("t4_fb", fb, 2'd1);
    step(1'b1, 5'd1, 5'd2, 5'd0, 1'b1, 1'b1, 1'b0, st, fa, fb, w);
    step(1'b1, 5'd1, 5'd0, 5'd13, 1'b1, 1'b0, 1'b0, st, fa, fb, w);
    chk("t4_x0_stall", st, 1'b0);
    nop(st, fa, fb, w);
    chk("t4_x0_fb", fb, 2'd0);

    // T5: flush overrides load-use
    step(1'b1, 5'd1, 5'd2, 5'd9, 1'b1, 1'b1, 1'b0, st, fa, fb, w);
    step(1'b1, 5'd9, 5'd9, 5'd14, 1'b1, 1'b0, 1'b1, st, fa, fb, w);
    chk("t5_stall", st, 1'b0);
    nop(st, fa, fb, w);
    chk("t5_fa", fa, 2'd0);
    chk("t5_fb", fb, 2'd0);
    chk("t5_load_wbw_pending", w, 1'b0);
    nop(st, fa, fb, w);
    chk("t5_load_wbw", w, 1'b1);
    nop(st, fa, fb, w);
    chk("t5_slot_wbw", w, 1'b0);

    // T6: random stream; a stalled instruction is re-presented
    st = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      if (!st) begin
        r_v   = ($urandom_range(0, 99) < 85);
        r_rs1 = 5'($urandom_range(0, 7));
        r_rs2 = 5'($urandom_range(0, 7));
        r_rd  = 5'($urandom_range(0, 7));
        r_w   = ($urandom_range(0, 99) < 80);
        r_l   = ($urandom_range(0, 99) < 30);
      end
      r_f = ($urandom_range(0, 99) < 5);
      step(r_v, r_rs1, r_rs2, r_rd, r_w, r_l, r_f, st, fa, fb, w);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, limit 2000000");
    $fatal(1);
  end

endmodule

// File: doc/fwd_hazard_ctrl.md
Name: fwd_hazard_ctrl

Overview:
- Control block that drives the 2-bit selectors of the EX-stage 3-to-1 operand forwarding muxes.
- Per-mux encoding: 0 = register-file operand, 1 = MEM/WB result, 2 = EX/MEM result.
- Tracks destination-register info of in-flight instructions through internal ID/EX, EX/MEM and MEM/WB shadow registers.
- Asserts a one-cycle load-use stall when forwarding cannot cover a dependency; sits beside the ID/EX pipeline register in the RISC-V core.

Parameters:
ADDR_W, 5, register address width (x0..x31)

Ports:
clk  input  1  core clock, rising-edge
rst  input  1  asynchronous active-high reset
id_valid  input  1  instruction in ID is valid
id_rs1  input  ADDR_W  ID source register 1
id_rs2  input  ADDR_W  ID source register 2
id_rd  input  ADDR_W  ID destination register
id_reg_write  input  1  ID instruction writes rd
id_mem_read  input  1  ID instruction is a load
flush  input  1  branch/jump taken: squash instruction entering EX
stall  output  1  hold PC and IF/ID this cycle (load-use)
fwd_a_sel  output  2  selector for rs1 forwarding mux
fwd_b_sel  output  2  selector for rs2 forwarding mux
ex_rd  output  ADDR_W  rd held in EX shadow stage
mem_rd  output  ADDR_W  rd held in MEM shadow stage
wb_rd  output  ADDR_W  rd held in WB shadow stage
wb_reg_write  output  1  WB instruction writes register file (valid-qualified)

Behaviour:
- Reset (async, rst=1): every shadow-register field (valid, rs1, rs2, rd, reg_write, mem_read) clears to 0 immediately. Outputs read 0: stall, fwd_a_sel, fwd_b_sel, ex_rd, mem_rd, wb_rd, wb_reg_write. First capture occurs on the first rising edge after rst falls.
- Shadow stages:
  - EX holds {valid, rs1, rs2, rd, reg_write, mem_read}.
  - MEM holds {valid, rd, reg_write, mem_read}.
  - WB holds {valid, rd, reg_write}.
- Advance on every rising edge: WB<=MEM and MEM<=EX, unconditionally.
- EX load per edge, in priority order:
  - flush=1: EX<=bubble (valid=0, all fields 0).
  - Otherwise, stall=1: EX<=bubble.
  - Otherwise: EX<={id_valid, id_rs1, id_rs2, id_rd, id_reg_write & id_valid, id_mem_read & id_valid}.
- stall (combinational) = !flush & id_valid & ex_valid & ex_mem_read & (ex_rd != 0) & ((ex_rd == id_rs1) | (ex_rd == id_rs2)).
  - Asserts for exactly one cycle per load-use pair: next cycle the load is in MEM and EX holds a bubble.
- fwd_a_sel (combinational, from registered state only; no dependence on id_* inputs):
  - 2 if ex_valid & mem_valid & mem_reg_write & mem_rd != 0 & mem_rd == ex_rs1;
  - else 1 if ex_valid & wb_valid & wb_reg_write & wb_rd != 0 & wb_rd == ex_rs1;
  - else 0.
  - When both MEM and WB match, MEM (younger) wins → 2.
- fwd_b_sel: identical rule using ex_rs2.
- Selector value 3 is never driven.
- x0 is never forwarded and never causes a stall.
- A load in MEM never matches ex_rs1/ex_rs2, because the stall guarantees this. The bench checks it as an invariant: sel==2 implies !mem_mem_read.
- ex_rd, mem_rd and wb_rd are the raw stage rd fields; wb_reg_write = wb_valid & wb_reg_write.
- Reset mid-operation: all in-flight state is discarded and no stall persists. Pipeline restarts empty.
- Latency: an instruction presented at ID with stall=0 appears in EX 1 cycle later, MEM 2 cycles, WB 3 cycles.

Test Plan:
1. Reset: rst=1 pulse mid-clock with stages full → all outputs 0 before the next edge; after release with id_valid=0 for 3 cycles → fwd_*_sel=0, stall=0.
2. EX/MEM forward: I1 add rd=5; next cycle I2 rs1=5, rs2=6 → in I2's EX cycle fwd_a_sel=2, fwd_b_sel=0; I2 rs2=5 instead → fwd_b_sel=2.
3. MEM/WB forward and priority:
   - I1 rd=7, unrelated I2, I3 rs1=7 → fwd_a_sel=1 in I3's EX cycle.
   - I1 rd=7, I2 rd=7, I3 rs1=7 → fwd_a_sel=2 (MEM wins).
4. Load-use: I1 load rd=9, I2 rs2=9 in ID next cycle → stall=1 for exactly 1 cycle, EX gets a bubble; when I2 reaches EX, fwd_b_sel=1. Load rd=0 with rs2=0 → stall=0, sel=0.
5. Flush: flush=1 in the same cycle as the load-use condition → stall=0, EX bubble. Following cycle, fwd sel=0 and wb_reg_write reaches 0 for that slot 2 cycles later.
6. Randomized 10k-instruction stream vs reference model: selectors match, never 3, and no sel=2 while mem_mem_read=1.
